// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Framebuffer fetch engine for a 640x480 VGA/HDMI timing generator. Reads 32-bit words of
//   RGB332 pixels over a simple strobe/ack bus into a small word FIFO, one line at a time. It
//   unpacks each word into four pixels and presents one expanded pixel per fetch_next strobe.
//   A vsync rising edge restarts the frame at base_addr. An hsync rising edge starts the next
//   line, or repeats the current one when line doubling is enabled.
//
//   Build option:
//     VGA_PIXEL_FETCH_LINE_REPEAT_EN  defined   -> line_repeat rewinds to the line start at hsync
//                                     undefined -> line_repeat is ignored, lines always advance
//
//   Ports:
//     clk_pixel    in   pixel clock, rising edge
//     resetn       in   asynchronous active-low reset
//     base_addr    in   frame start word address, sampled at the vsync rising edge
//     rd_addr      out  bus read word address, stable while rd_strobe waits for rd_ack
//     rd_strobe    out  bus read request
//     rd_ack       in   read data valid, completes the request
//     rd_data      in   read data, pixel 0 in bits [7:0]
//     fetch_next   in   consume the current pixel; the new pixel shows on the next cycle
//     line_repeat  in   repeat the current line at the next hsync (build option)
//     vga_hsync    in   active-high horizontal sync
//     vga_vsync    in   active-high vertical sync
//     red_byte, green_byte, blue_byte, bright_byte  out  expanded current pixel
//     underflow    out  sticky: fetch_next seen with no pixel available, cleared by vsync

module vga_pixel_fetch #(
  parameter int unsigned ADDR_WIDTH      = 30,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned LINE_WORDS      = 160
) (
  input  logic                  clk_pixel,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_strobe,
  input  logic                  rd_ack,
  input  logic [31:0]           rd_data,
  input  logic                  fetch_next,
  input  logic                  line_repeat,
  input  logic                  vga_hsync,
  input  logic                  vga_vsync,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underflow
);

  localparam int unsigned Depth    = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CntW     = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PtrW     = FIFO_DEPTH_LOG2;
  localparam int unsigned LineCntW = $clog2(LINE_WORDS + 1);

  localparam logic [CntW-1:0]     DepthC     = CntW'(Depth);
  localparam logic [LineCntW-1:0] LineWordsC = LineCntW'(LINE_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLineEnd,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  strobe_q, strobe_d;
  logic [LineCntW-1:0]   line_cnt_q, line_cnt_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            pix_q, pix_d;
  logic                  underflow_q, underflow_d;
  logic                  vsync_q, hsync_q;

`ifdef VGA_PIXEL_FETCH_LINE_REPEAT_EN
  logic [ADDR_WIDTH-1:0] line_start_q, line_start_d;
`else
  logic                  unused_line_repeat;
  assign unused_line_repeat = line_repeat;
`endif

  logic [31:0] mem [Depth];
  logic [31:0] head_word;
  logic [7:0]  head_byte;

  logic vsync_rise, hsync_rise;
  logic ack_ok;
  logic push, pop, flush;
  logic new_req;

  assign vsync_rise = vga_vsync & ~vsync_q;
  assign hsync_rise = vga_hsync & ~hsync_q;
  assign ack_ok     = strobe_q & rd_ack;

  assign head_word = mem[rd_ptr_q];

  always_comb begin
    head_byte = 8'h00;
    unique case (idx_q)
      2'd0:    head_byte = head_word[7:0];
      2'd1:    head_byte = head_word[15:8];
      2'd2:    head_byte = head_word[23:16];
      default: head_byte = head_word[31:24];
    endcase
  end

  // Next-state: unpacker, line/frame sequencer and bus request.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    line_cnt_d  = line_cnt_q;
    idx_d       = idx_q;
    pix_d       = pix_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
`ifdef VGA_PIXEL_FETCH_LINE_REPEAT_EN
    line_start_d = line_start_q;
`endif

    // Unpacker: the head word pops when its last pixel is consumed.
    if (fetch_next) begin
      if (fifo_cnt_q != '0) begin
        pix_d = head_byte;
        idx_d = idx_q + 2'd1;
        pop   = (idx_q == 2'd3);
      end else begin
        pix_d       = 8'h00;
        underflow_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
      end
      StFetch: begin
        if (ack_ok) begin
          push       = 1'b1;
          addr_d     = addr_q + 1'b1;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q + 1'b1 == LineWordsC) begin
            state_d = StLineEnd;
          end
        end
      end
      StLineEnd: begin
        if (hsync_rise) begin
`ifdef VGA_PIXEL_FETCH_LINE_REPEAT_EN
          if (line_repeat) begin
            addr_d = line_start_q;
          end else begin
            line_start_d = addr_q;
          end
`endif
          line_cnt_d = '0;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        // The request issued before vsync completes here; its data belongs to the old frame.
        if (ack_ok) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame restart overrides everything else in the same cycle, including an ack push.
    if (vsync_rise) begin
      flush       = 1'b1;
      push        = 1'b0;
      pop         = 1'b0;
      idx_d       = 2'd0;
      underflow_d = 1'b0;
      addr_d      = base_addr;
      line_cnt_d  = '0;
`ifdef VGA_PIXEL_FETCH_LINE_REPEAT_EN
      line_start_d = base_addr;
`endif
      state_d = (strobe_q && !rd_ack) ? StDrain : StFetch;
    end
  end

  // FIFO bookkeeping.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Bus request. The strobe is decided from next-cycle occupancy, so a request is only made
  // when its word is guaranteed a slot. While a request waits, occupancy can only fall and the
  // line count is frozen, so the strobe holds until rd_ack.
  always_comb begin
    strobe_d = 1'b0;
    unique case (state_d)
      StDrain: strobe_d = 1'b1;
      StFetch: strobe_d = (fifo_cnt_d < DepthC) && (line_cnt_d < LineWordsC);
      default: strobe_d = 1'b0;
    endcase
    // The address only moves when a fresh request starts, never under a pending one.
    new_req   = strobe_d && (!strobe_q || ack_ok);
    rd_addr_d = new_req ? addr_d : rd_addr_q;
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      strobe_q    <= 1'b0;
      line_cnt_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= 2'd0;
      pix_q       <= 8'h00;
      underflow_q <= 1'b0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      strobe_q    <= strobe_d;
      line_cnt_q  <= line_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
      vsync_q     <= vga_vsync;
      hsync_q     <= vga_hsync;
    end
  end

`ifdef VGA_PIXEL_FETCH_LINE_REPEAT_EN
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      line_start_q <= '0;
    end else begin
      line_start_q <= line_start_d;
    end
  end
`endif

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem[wr_ptr_q] <= rd_data;
    end
  end

  // RGB332 expansion replicates each field's high bits to fill 8 bits.
  assign red_byte    = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
  assign green_byte  = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
  assign blue_byte   = {4{pix_q[1:0]}};
  assign bright_byte = pix_q;

  assign rd_strobe = strobe_q;
  assign rd_addr   = rd_addr_q;
  assign underflow = underflow_q;

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Upstream feeder for the 640x480 VGA/HDMI timing generator. A bus-master fetch engine reads 32-bit words of 8bpp RGB332 framebuffer data into a small word FIFO, one frame line at a time. It unpacks each word into four pixels and presents one pixel's red/green/blue/bright bytes at a time, advancing on the generator's `fetch_next` strobe. It also honours `line_repeat` for Y doubling and restarts the frame on `vga_vsync`.

## Interface
- `ADDR_WIDTH`, 30: word-address width.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is 2^n words (16).
- `LINE_WORDS`, 160: words per line (640 px / 4).
- `clk_pixel`  in  1  pixel clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `base_addr`  in  ADDR_WIDTH  frame start word address; sampled at vsync rising edge.
- `rd_addr`  out  ADDR_WIDTH  bus read word address.
- `rd_strobe`  out  1  bus read request.
- `rd_ack`  in  1  read data valid; completes the request.
- `rd_data`  in  32  read data; pixel 0 in bits [7:0].
- `fetch_next`  in  1  consume current pixel.
- `line_repeat`  in  1  repeat the current line at the next hsync.
- `vga_hsync`, `vga_vsync`  in  1  active-high sync pulses from the timing generator.
- `red_byte`, `green_byte`, `blue_byte`, `bright_byte`  out  8  current pixel.
- `underflow`  out  1  sticky: `fetch_next` arrived while no pixel was available.

## Operation
- **Pixel expansion:** pixel p = RRRGGGBB.
  - `red_byte` = {p[7:5],p[7:5],p[7:6]}
  - `green_byte` = {p[4:2],p[4:2],p[4:3]}
  - `blue_byte` = {4{p[1:0]}}
  - `bright_byte` = p
- **Unpacker:** holds the FIFO head word plus a 2-bit pixel index.
  - On `fetch_next`, the output registers load pixel[index] and the index increments.
  - When the index wraps 3→0, the head word pops.
  - If the FIFO is empty on `fetch_next`, outputs load 0 and `underflow` sets.
- **FSM states:** IDLE, FETCH, LINE_END, DRAIN.
- **IDLE:** entered from reset. Waits for the `vga_vsync` rising edge.
- **FETCH:**
  - Asserts `rd_strobe` with `rd_addr` = addr whenever the FIFO is not full and the line word count is below `LINE_WORDS`.
  - The strobe and address are held stable until `rd_ack`.
  - On `rd_ack`: push `rd_data`, addr+1, count+1.
  - When count reaches `LINE_WORDS`, go to LINE_END.
- **LINE_END:** waits for the `vga_hsync` rising edge.
  - If `line_repeat`=1 at that edge, addr ← line_start.
  - Otherwise line_start ← addr.
  - Count ← 0, go to FETCH.
- **Vsync** (rising edge in any state):
  - FIFO and pixel index are flushed; `underflow` clears.
  - addr ← line_start ← `base_addr`; count ← 0.
  - If a request is outstanding (`rd_strobe`=1, no ack this cycle), go to DRAIN. Otherwise go to FETCH.
- **DRAIN:** keeps `rd_strobe` high until `rd_ack`, discards the data, then goes to FETCH.
- **Address wrap:** the address wraps modulo 2^ADDR_WIDTH.

## Timing
- **Reset values:**
  - `rd_strobe`=0, `rd_addr`=0.
  - All pixel bytes 0, `underflow`=0.
  - FIFO empty, FSM in IDLE.
- **Output latency:** a `fetch_next` at cycle N makes the new pixel visible at N+1. This matches the generator drawing one cycle after fetch.
- **Strobe:** `rd_strobe` can assert the cycle after FIFO space appears. Back-to-back requests are allowed: strobe stays high across consecutive acks while not full.
- **Pop + push in the same cycle:** legal. The count is unchanged. A full FIFO that pops while acked never overflows, because a request is only issued when count < depth counting the outstanding request.
- **Edge detection:** sync edges are detected against a 1-cycle registered copy of the sync input. Vsync takes priority over hsync and over `rd_ack` pushes in the same cycle.
- **First pixel:** on the first active line, 4 words must land before the first `fetch_next`. This is guaranteed when bus latency is under 30 cycles.

## Configuration
- **`VGA_PIXEL_FETCH_LINE_REPEAT_EN` defined:** `line_repeat` is honoured as above.
- **Undefined:** the `line_repeat` port is present but ignored. LINE_END always advances line_start ← addr, and no line_start rewind logic is built.

## Test plan
- **Reset:** assert `resetn`=0 mid-FETCH with strobe high → next cycle `rd_strobe`=0, bytes 0, FSM IDLE.
- **Basic fetch:** `base_addr`=0x100, vsync pulse, memory word 0x1C03E0FF at 0x100 with 1-cycle ack → strobe addr 0x100. Four `fetch_next` give `bright_byte` 0xFF, 0xE0, 0x03, 0x1C. Red for 0xE0 is 0xFF, blue for 0x03 is 0xFF.
- **Line sequencing:** full 160-word line → strobe stops after addr 0x19F. After the hsync edge, fetch resumes at 0x1A0.
- **Line repeat (macro defined):** `line_repeat`=1 at the hsync edge → next fetch restarts at 0x100. With the macro undefined → restarts at 0x1A0.
- **Vsync mid-request:** vsync edge while strobe is pending, ack 3 cycles later → data discarded, FIFO empty, next strobe at `base_addr`.
- **Underflow:** stall `rd_ack` and issue `fetch_next` with the FIFO empty → bytes 0, `underflow`=1. The flag holds until the next vsync.
